adder_accumulator: RTL and testbench



---
 rtl/adder_accumulator.sv | 130 +++++++++++++
 tb/tb_adder_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_accumulator.sv
// Streaming 16-bit accumulator with valid/ready input and valid/ack result handshake.
// Optional build macro ACCUM_SATURATE_EN clamps the accumulator at 16'hFFFF on carry-out.

module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        overflow
);
  // Unsigned add; bit 16 of the widened sum is the carry-out.
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, carry_in};
endmodule

module adder_accumulator #(
  parameter int NUM_SAMPLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             data_valid,
  input  logic [15:0]      data_in,
  output logic             data_ready,
  output logic [15:0]      result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             overflow_flag,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [15:0]      acc_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;
  logic             data_ready_r;
  logic             result_valid_r;

  logic [15:0]      sum_s;
  logic             carry_s;
  logic [15:0]      acc_next_s;
  logic             xfer_s;

  adder_16bit u_adder (
    .a        (acc_r),
    .b        (data_in),
    .carry_in (1'b0),
    .sum      (sum_s),
    .overflow (carry_s)
  );

  // data_ready_r is only ever high in ACCUM, so it alone qualifies a transfer.
  assign xfer_s = data_valid & data_ready_r;

  // Select the value loaded into the accumulator on a transfer.
  always_comb begin
    acc_next_s = sum_s;
`ifdef ACCUM_SATURATE_EN
    if (carry_s) begin
      acc_next_s = 16'hFFFF;
    end else begin
      acc_next_s = sum_s;
    end
`endif
  end

  // Control FSM together with the accumulator datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r        <= IDLE;
      acc_r          <= 16'h0000;
      ovf_r          <= 1'b0;
      cnt_r          <= '0;
      data_ready_r   <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= ACCUM;
            acc_r        <= 16'h0000;
            ovf_r        <= 1'b0;
            cnt_r        <= '0;
            data_ready_r <= 1'b1;
          end
        end
        ACCUM: begin
          if (xfer_s) begin
            acc_r <= acc_next_s;
            ovf_r <= ovf_r | carry_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == LAST_CNT) begin
              state_r        <= DONE;
              data_ready_r   <= 1'b0;
              result_valid_r <= 1'b1;
            end
          end
        end
        DONE: begin
          // start is deliberately not examined here, even alongside result_ack.
          if (result_ack) begin
            state_r        <= IDLE;
            result_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          data_ready_r   <= 1'b0;
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready    = data_ready_r;
  assign result_valid  = result_valid_r;
  assign result        = acc_r;
  assign overflow_flag = ovf_r;
  assign sample_count  = cnt_r;

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed, scoreboard-based bench for adder_accumulator (NUM_SAMPLES=8, CNT_W=4).
// Expected overflow results follow ACCUM_SATURATE_EN when the bench is built with it.

module tb_adder_accumulator;

  localparam int NS = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          data_valid;
  logic [15:0]   data_in;
  logic          data_ready;
  logic [15:0]   result;
  logic          result_valid;
  logic          result_ack;
  logic          overflow_flag;
  logic [CW-1:0] sample_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;
  logic [15:0] ops [8];

  adder_accumulator #(.NUM_SAMPLES(NS), .CNT_W(CW)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .data_valid    (data_valid),
    .data_in       (data_in),
    .data_ready    (data_ready),
    .result        (result),
    .result_valid  (result_valid),
    .result_ack    (result_ack),
    .overflow_flag (overflow_flag),
    .sample_count  (sample_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned accumulate with wrap, or clamp when saturation is built in.
  function automatic exp_t model(input logic [15:0] v [8]);
    logic [16:0] s;
    exp_t e;
    e = '0;
    for (int i = 0; i < NS; i++) begin
      s = {1'b0, e.res} + {1'b0, v[i]};
      if (s[16]) e.ovf = 1'b1;
`ifdef ACCUM_SATURATE_EN
      e.res = s[16] ? 16'hFFFF : s[15:0];
`else
      e.res = s[15:0];
`endif
    end
    return e;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", {31'd0, data_ready}, 32'd1);
    chk("start_clr_ovf", {31'd0, overflow_flag}, 32'd0);
    chk("start_clr_cnt", {28'd0, sample_count}, 32'd0);
    chk("start_clr_acc", {16'd0, result}, 32'd0);
  endtask

  task automatic feed(input logic [15:0] v [8], input bit stall);
    sb.push_back(model(v));
    for (int i = 0; i < NS; i++) begin
      if (stall) begin
        data_valid = 1'b0;
        data_in    = 16'hDEAD;
        @(negedge clk);
      end
      data_valid = 1'b1;
      data_in    = v[i];
      if (i == NS - 1) chk("rv_early", {31'd0, result_valid}, 32'd0);
      @(negedge clk);
    end
    data_valid = 1'b0;
    chk("rv_latency", {31'd0, result_valid}, 32'd1);
  endtask

  task automatic get_result();
    int n = 0;
    while (result_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rv_timeout", {31'd0, result_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      cur = '0;
    end else begin
      cur = sb.pop_front();
      chk("result", {16'd0, result}, {16'd0, cur.res});
      chk("overflow", {31'd0, overflow_flag}, {31'd0, cur.ovf});
      chk("count", {28'd0, sample_count}, NS);
      chk("done_ready", {31'd0, data_ready}, 32'd0);
    end
  endtask

  task automatic ack();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk("ack_rv_fall", {31'd0, result_valid}, 32'd0);
    chk("ack_idle_ready", {31'd0, data_ready}, 32'd0);
  endtask

  initial begin
    n_rst      = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
    data_in    = 16'h0000;
    result_ack = 1'b0;
    #12;
    chk("rst_ready", {31'd0, data_ready}, 32'd0);
    chk("rst_rv", {31'd0, result_valid}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_flag}, 32'd0);
    chk("rst_cnt", {28'd0, sample_count}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // IDLE ignores upstream data.
    data_valid = 1'b1;
    data_in    = 16'h1234;
    repeat (3) @(negedge clk);
    chk("idle_ready", {31'd0, data_ready}, 32'd0);
    chk("idle_cnt", {28'd0, sample_count}, 32'd0);
    chk("idle_result", {16'd0, result}, 32'd0);
    data_valid = 1'b0;

    // Basic sum 1..8.
    ops = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    do_start();
    feed(ops, 1'b0);
    get_result();
    ack();
    chk("idle_holds_result", {16'd0, result}, 32'h24);

    // Same operands with alternate-cycle stalls.
    do_start();
    feed(ops, 1'b1);
    get_result();
    ack();

    // Overflow run, then hold DONE with a stray start pulse.
    ops = '{16'hFFFF, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_start();
    feed(ops, 1'b0);
    get_result();
    for (int c = 0; c < 10; c++) begin
      start = (c == 4);
      @(negedge clk);
      chk("hold_result", {16'd0, result}, {16'd0, cur.res});
      chk("hold_rv", {31'd0, result_valid}, 32'd1);
      chk("hold_ovf", {31'd0, overflow_flag}, {31'd0, cur.ovf});
      chk("hold_cnt", {28'd0, sample_count}, NS);
    end
    start      = 1'b1;
    result_ack = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    result_ack = 1'b0;
    chk("ackstart_rv", {31'd0, result_valid}, 32'd0);
    chk("ackstart_ready", {31'd0, data_ready}, 32'd0);
    @(negedge clk);
    chk("ackstart_no_run", {31'd0, data_ready}, 32'd0);
    chk("ackstart_result", {16'd0, result}, {16'd0, cur.res});

    // Back-to-back run after overflow: eight ones.
    ops = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    do_start();
    feed(ops, 1'b0);
    get_result();
    chk("b2b_result", {16'd0, result}, 32'h8);
    ack();

    // Asynchronous reset in the middle of ACCUM.
    do_start();
    data_valid = 1'b1;
    data_in    = 16'h0010;
    repeat (3) @(negedge clk);
    chk("mid_cnt", {28'd0, sample_count}, 32'd3);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mrst_ready", {31'd0, data_ready}, 32'd0);
    chk("mrst_rv", {31'd0, result_valid}, 32'd0);
    chk("mrst_result", {16'd0, result}, 32'd0);
    chk("mrst_ovf", {31'd0, overflow_flag}, 32'd0);
    chk("mrst_cnt", {28'd0, sample_count}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", {31'd0, data_ready}, 32'd0);
    chk("post_rst_cnt", {28'd0, sample_count}, 32'd0);
    chk("post_rst_rv", {31'd0, result_valid}, 32'd0);
    data_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
